// File: rtl/prbs_pkg.sv
// Shared types and the LFSR feedback function used by both the PRBS generator and checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // Callers zero-extend to 32 bits so one function serves any LFSR length up to 32.
  function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] poly);
    return ^(state & poly);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds a local LFSR from the received stream, verifies it,
// then free-runs while locked to count bit errors and drops lock on an error burst.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 32,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] poly,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   r_reg, r_next;
  logic [WIDTH-1:0]   poly_q;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic [RUN_W-1:0]   run_reg, run_next;
  logic [WIN_W-1:0]   win_cnt_reg, win_cnt_next;
  logic [WERR_W-1:0]  win_err_reg, win_err_next;
  logic               err_pulse_next;
  logic               err_inc;
  logic               pred;
  logic               mismatch;
  logic [WIDTH-1:0]   shift_in;
  logic [WERR_W-1:0]  werr_sum;

  assign pred     = lfsr_fb(32'(r_reg), 32'(poly_q));
  assign mismatch = in_bit ^ pred;
  assign shift_in = {in_bit, r_reg[WIDTH-1:1]};
  assign werr_sum = win_err_reg + WERR_W'(mismatch);

  always_comb begin
    state_next     = state_reg;
    r_next         = r_reg;
    fill_next      = fill_reg;
    run_next       = run_reg;
    win_cnt_next   = win_cnt_reg;
    win_err_next   = win_err_reg;
    err_pulse_next = 1'b0;
    err_inc        = 1'b0;
    if (in_valid) begin
      case (state_reg)
        SEED: begin
          r_next = shift_in;
          // Once full, fill parks so every further bit re-tests for a non-zero seed.
          if (fill_reg == FILL_W'(WIDTH - 1)) begin
            if (shift_in != '0) begin
              state_next = VERIFY;
              run_next   = '0;
            end
          end else begin
            fill_next = fill_reg + 1'b1;
          end
        end
        VERIFY: begin
          r_next = shift_in;
          if (!mismatch) begin
            if (run_reg == RUN_W'(LOCK_CNT - 1)) begin
              state_next   = LOCKED;
              win_cnt_next = '0;
              win_err_next = '0;
            end else begin
              run_next = run_reg + 1'b1;
            end
          end else begin
            state_next = SEED;
            fill_next  = '0;
            run_next   = '0;
          end
        end
        LOCKED: begin
          // Free-running on the prediction keeps one flipped bit from corrupting later ones.
          r_next         = {pred, r_reg[WIDTH-1:1]};
          err_pulse_next = mismatch;
          err_inc        = mismatch;
          if (werr_sum == WERR_W'(LOSS_THRESH)) begin
            state_next = SEED;
            fill_next  = '0;
            run_next   = '0;
            r_next     = '0;
          end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_reg + 1'b1;
            win_err_next = werr_sum;
          end
        end
        default: begin
          state_next = SEED;
          fill_next  = '0;
          run_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= SEED;
      r_reg       <= '0;
      poly_q      <= poly;
      fill_reg    <= '0;
      run_reg     <= '0;
      win_cnt_reg <= '0;
      win_err_reg <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      r_reg       <= r_next;
      fill_reg    <= fill_next;
      run_reg     <= run_next;
      win_cnt_reg <= win_cnt_next;
      win_err_reg <= win_err_next;
      locked      <= (state_next == LOCKED);
      err_pulse   <= err_pulse_next;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_cnt),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule
